// File: rtl/ifu_ibuf_pkg.sv
// Shared IFU/IDU instruction-buffer constants and entry type.
// The fetch unit sizes its request window against IBUF_AFULL_TH.
package ifu_ibuf_pkg;
  localparam int IBUF_PC_W     = 64;
  localparam int IBUF_INST_W   = 32;
  localparam int IBUF_DEPTH    = 8;
  localparam int IBUF_PTR_W    = $clog2(IBUF_DEPTH);
  localparam int IBUF_AFULL_TH = 6;

  typedef struct packed {
    logic [IBUF_PC_W-1:0]   pc;
    logic [IBUF_INST_W-1:0] inst;
  } ibuf_entry_t;
endpackage

// File: rtl/ifu_ibuf_if.sv
// Fetch-side write port, ID-side head port and control for the instruction buffer.
interface ifu_ibuf_if import ifu_ibuf_pkg::*; #(
  parameter int PTR_W = IBUF_PTR_W
) ();
  logic                   rtu_global_flush;
  logic                   ifu_ibuf_wr_vld;
  logic [IBUF_PC_W-1:0]   ifu_ibuf_wr_pc;
  logic [IBUF_INST_W-1:0] ifu_ibuf_wr_inst;
  logic                   ibuf_wr_rdy;
  logic                   ibuf_afull;
  logic [PTR_W:0]         ibuf_cnt;
  logic                   y_idu_id_stall_ctrl;
  logic                   ifu_idu_id_inst_vld;
  logic [IBUF_PC_W-1:0]   ifu_idu_id_inst_pc;
  logic [IBUF_INST_W-1:0] ifu_idu_id_inst;

  modport master (
    output rtu_global_flush, ifu_ibuf_wr_vld, ifu_ibuf_wr_pc, ifu_ibuf_wr_inst, y_idu_id_stall_ctrl,
    input  ibuf_wr_rdy, ibuf_afull, ibuf_cnt, ifu_idu_id_inst_vld, ifu_idu_id_inst_pc, ifu_idu_id_inst
  );

  modport slave (
    input  rtu_global_flush, ifu_ibuf_wr_vld, ifu_ibuf_wr_pc, ifu_ibuf_wr_inst, y_idu_id_stall_ctrl,
    output ibuf_wr_rdy, ibuf_afull, ibuf_cnt, ifu_idu_id_inst_vld, ifu_idu_id_inst_pc, ifu_idu_id_inst
  );
endinterface

// File: rtl/ifu_ibuf.sv
// IFU->IDU instruction buffer: DEPTH-entry FIFO of {pc, inst}, one release per
// unstalled cycle, combinational head read, emptied on global flush.
module ifu_ibuf import ifu_ibuf_pkg::*; #(
  parameter int DEPTH    = IBUF_DEPTH,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int AFULL_TH = IBUF_AFULL_TH
) (
  input  logic       clk,
  input  logic       rst_clk,
  ifu_ibuf_if.slave  bif
);
  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_AFULL = (PTR_W+1)'(AFULL_TH);

  ibuf_entry_t       mem [DEPTH];
  ibuf_entry_t       head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    cnt;
  logic              empty, full, flush, push, pop;

  assign flush = bif.rtu_global_flush;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_FULL);
  // full blocks the push even when a pop frees a slot this cycle
  assign push  = bif.ifu_ibuf_wr_vld & ~full & ~flush;
  assign pop   = ~empty & ~bif.y_idu_id_stall_ctrl & ~flush;

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{pc: bif.ifu_ibuf_wr_pc, inst: bif.ifu_ibuf_wr_inst};
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk)   cnt <= '0;
    else if (flush) cnt <= '0;
    else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // storage is not cleared on flush; stale entries are hidden by the empty gate
  assign head                    = mem[rd_ptr];
  assign bif.ifu_idu_id_inst_vld = ~empty;
  assign bif.ifu_idu_id_inst_pc  = empty ? '0 : head.pc;
  assign bif.ifu_idu_id_inst     = empty ? '0 : head.inst;
  assign bif.ibuf_wr_rdy         = ~full;
  assign bif.ibuf_afull          = (cnt >= CNT_AFULL);
  assign bif.ibuf_cnt            = cnt;

  a_cnt_max:  assert property (@(posedge clk) disable iff (!rst_clk) cnt <= CNT_FULL);
  a_ptr_diff: assert property (@(posedge clk) disable iff (!rst_clk)
                               (wr_ptr - rd_ptr) == cnt[PTR_W-1:0]);
  a_no_ovf:   assert property (@(posedge clk) disable iff (!rst_clk) !(push && full));
  a_no_unf:   assert property (@(posedge clk) disable iff (!rst_clk) !(pop && empty));
endmodule

// File: tb/tb_ifu_ibuf.sv
// Directed bench for ifu_ibuf: queue scoreboard checked by a negedge monitor,
// plus hand-computed spot checks from the driver.
module tb_ifu_ibuf;
  import ifu_ibuf_pkg::*;

  logic clk;
  logic rst_clk;
  int   checks   = 0;
  int   failures = 0;

  ifu_ibuf_if bif ();
  ifu_ibuf dut (.clk(clk), .rst_clk(rst_clk), .bif(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibuf_entry_t exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: compare head/status against model, then apply this cycle's push/pop
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (!rst_clk) begin
        exp_q.delete();
        continue;
      end
      n = exp_q.size();
      chk("sb_cnt",    64'(bif.ibuf_cnt), 64'(n));
      chk("sb_vld",    64'(bif.ifu_idu_id_inst_vld), 64'(n > 0));
      chk("sb_wr_rdy", 64'(bif.ibuf_wr_rdy), 64'(n < 8));
      chk("sb_afull",  64'(bif.ibuf_afull), 64'(n >= 6));
      if (n > 0) begin
        chk("sb_head_pc",   bif.ifu_idu_id_inst_pc, exp_q[0].pc);
        chk("sb_head_inst", 64'(bif.ifu_idu_id_inst), 64'(exp_q[0].inst));
      end else begin
        chk("sb_empty_pc",   bif.ifu_idu_id_inst_pc, 64'd0);
        chk("sb_empty_inst", 64'(bif.ifu_idu_id_inst), 64'd0);
      end
      if (bif.rtu_global_flush) exp_q.delete();
      else begin
        if (n > 0 && !bif.y_idu_id_stall_ctrl) void'(exp_q.pop_front());
        if (bif.ifu_ibuf_wr_vld && n < 8)
          exp_q.push_back('{pc: bif.ifu_ibuf_wr_pc, inst: bif.ifu_ibuf_wr_inst});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bif.ifu_ibuf_wr_vld  = 1'b1;
      bif.ifu_ibuf_wr_pc   = base + 64'(4 * i);
      bif.ifu_ibuf_wr_inst = 32'h0000_0013 + 32'(i);
      step();
    end
    bif.ifu_ibuf_wr_vld = 1'b0;
  endtask

  task automatic drain();
    int budget = 20;
    bif.y_idu_id_stall_ctrl = 1'b0;
    bif.ifu_ibuf_wr_vld     = 1'b0;
    while (bif.ifu_idu_id_inst_vld && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_timeout", 64'(bif.ifu_idu_id_inst_vld), 64'd0);
  endtask

  localparam logic [63:0] BASE = 64'h8000_0000;

  initial begin
    rst_clk                 = 1'b0;
    bif.rtu_global_flush    = 1'b0;
    bif.ifu_ibuf_wr_vld     = 1'b0;
    bif.ifu_ibuf_wr_pc      = '0;
    bif.ifu_ibuf_wr_inst    = '0;
    bif.y_idu_id_stall_ctrl = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",    64'(bif.ifu_idu_id_inst_vld), 64'd0);
    chk("rst_pc",     bif.ifu_idu_id_inst_pc, 64'd0);
    chk("rst_inst",   64'(bif.ifu_idu_id_inst), 64'd0);
    chk("rst_wr_rdy", 64'(bif.ibuf_wr_rdy), 64'd1);
    chk("rst_afull",  64'(bif.ibuf_afull), 64'd0);
    chk("rst_cnt",    64'(bif.ibuf_cnt), 64'd0);
    rst_clk = 1'b1;
    step();

    // fill under stall; the 9th offer is refused
    bif.y_idu_id_stall_ctrl = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bif.ifu_ibuf_wr_vld  = 1'b1;
      bif.ifu_ibuf_wr_pc   = BASE + 64'(4 * i);
      bif.ifu_ibuf_wr_inst = 32'h0000_0013;
      step();
      chk("fill_cnt",    64'(bif.ibuf_cnt), 64'((i + 1 > 8) ? 8 : i + 1));
      chk("fill_afull",  64'(bif.ibuf_afull), 64'(i + 1 >= 6));
      chk("fill_wr_rdy", 64'(bif.ibuf_wr_rdy), 64'(i + 1 < 8));
      chk("fill_head",   bif.ifu_idu_id_inst_pc, BASE);
    end

    // drain while pushing: first cycle is full+pop (push refused), then steady at 7
    bif.y_idu_id_stall_ctrl = 1'b0;
    for (int j = 0; j < 12; j++) begin
      bif.ifu_ibuf_wr_vld = 1'b1;
      bif.ifu_ibuf_wr_pc  = BASE + 64'(4 * (9 + j));
      step();
      chk("wrap_cnt", 64'(bif.ibuf_cnt), 64'd7);
    end
    drain();

    // stall hold at cnt=3
    bif.y_idu_id_stall_ctrl = 1'b1;
    push_n(64'h9000_0000, 3);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_pc",   bif.ifu_idu_id_inst_pc, 64'h9000_0000);
      chk("hold_inst", 64'(bif.ifu_idu_id_inst), 64'h13);
      chk("hold_cnt",  64'(bif.ibuf_cnt), 64'd3);
    end
    bif.y_idu_id_stall_ctrl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rel_vld", 64'(bif.ifu_idu_id_inst_vld), 64'd1);
      chk("rel_pc",  bif.ifu_idu_id_inst_pc, 64'h9000_0000 + 64'(4 * k));
      step();
    end
    chk("rel_empty", 64'(bif.ifu_idu_id_inst_vld), 64'd0);

    // flush at cnt=5 with push and pop in the same cycle
    bif.y_idu_id_stall_ctrl = 1'b1;
    push_n(64'hA000_0000, 5);
    chk("pre_flush_cnt", 64'(bif.ibuf_cnt), 64'd5);
    bif.y_idu_id_stall_ctrl = 1'b0;
    bif.ifu_ibuf_wr_vld     = 1'b1;
    bif.ifu_ibuf_wr_pc      = 64'hDEAD_0000;
    bif.rtu_global_flush    = 1'b1;
    step();
    bif.rtu_global_flush = 1'b0;
    bif.ifu_ibuf_wr_vld  = 1'b0;
    chk("flush_cnt", 64'(bif.ibuf_cnt), 64'd0);
    chk("flush_vld", 64'(bif.ifu_idu_id_inst_vld), 64'd0);
    chk("flush_pc",  bif.ifu_idu_id_inst_pc, 64'd0);
    push_n(64'hB000_0000, 1);
    chk("post_flush_pc", bif.ifu_idu_id_inst_pc, 64'hB000_0000);
    step();
    chk("post_flush_empty", 64'(bif.ifu_idu_id_inst_vld), 64'd0);

    // full + pop + push offer in one cycle
    bif.y_idu_id_stall_ctrl = 1'b1;
    push_n(64'hC000_0000, 8);
    chk("full_wr_rdy", 64'(bif.ibuf_wr_rdy), 64'd0);
    bif.y_idu_id_stall_ctrl = 1'b0;
    bif.ifu_ibuf_wr_vld     = 1'b1;
    bif.ifu_ibuf_wr_pc      = 64'hC000_0100;
    step();
    bif.ifu_ibuf_wr_vld     = 1'b0;
    bif.y_idu_id_stall_ctrl = 1'b1;
    chk("fullpop_cnt",    64'(bif.ibuf_cnt), 64'd7);
    chk("fullpop_wr_rdy", 64'(bif.ibuf_wr_rdy), 64'd1);
    chk("fullpop_head",   bif.ifu_idu_id_inst_pc, 64'hC000_0004);
    drain();

    // asynchronous reset mid-operation
    bif.y_idu_id_stall_ctrl = 1'b1;
    push_n(64'hE000_0000, 3);
    #2 rst_clk = 1'b0;
    #1;
    chk("arst_cnt",    64'(bif.ibuf_cnt), 64'd0);
    chk("arst_vld",    64'(bif.ifu_idu_id_inst_vld), 64'd0);
    chk("arst_wr_rdy", 64'(bif.ibuf_wr_rdy), 64'd1);
    step();
    rst_clk = 1'b1;
    bif.y_idu_id_stall_ctrl = 1'b0;
    step();
    chk("arst_after_vld", 64'(bif.ifu_idu_id_inst_vld), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
